// File: rtl/lolap_inv_iter.sv
// Iterative inverse of the 257-bit LolaP permutation.
// One inverse round is applied per clock, from round NR_ROUNDS-1 down to 0.
// Each round type has one combinational instance, and a mux picks the result
// for the current round index.
//
// Forward round definitions that these primitives undo (x is the 257-bit
// state; L = x[127:0], H = x[256:128]):
//   wo-type: L ^= (x[255:128] & x[256:129]) ^ C_WO, then rotate left by 5.
//   w-type : H ^= g(L), then rotate left by 11, where
//            g(L) = {L[0]&L[1], L ^ (rotl128(L,1) & rotl128(L,2)) ^ C_W}.
// Each forward round is a Feistel-style step on an unchanged half. The
// inverse first undoes the rotation, then XORs the same mask again.

// Inverse of LolaP_round_wo: rotate right by 5, then remove the mask that the
// untouched high half puts on the low half.
module LolaP_round_wo_inv (
  input  logic [256:0] din,
  output logic [256:0] dout
);
  localparam logic [127:0] C_WO = 128'h243F6A8885A308D313198A2E03707344;

  logic [256:0] z;

  assign z    = {din[4:0], din[256:5]};
  assign dout = {z[256:128], z[127:0] ^ (z[255:128] & z[256:129]) ^ C_WO};
endmodule

// Inverse of LolaP_round_w: rotate right by 11, then remove the mask that the
// untouched low half puts on the high half.
module LolaP_round_w_inv (
  input  logic [256:0] din,
  output logic [256:0] dout
);
  localparam logic [127:0] C_W = 128'hA4093822299F31D0082EFA98EC4E6C89;

  logic [256:0] z;
  logic [127:0] l;
  logic [128:0] g;

  assign z    = {din[10:0], din[256:11]};
  assign l    = z[127:0];
  assign g    = {l[0] & l[1], l ^ ({l[126:0], l[127]} & {l[125:0], l[127:126]}) ^ C_W};
  assign dout = {z[256:128] ^ g, l};
endmodule

module lolap_inv_iter #(
  parameter int NR_ROUNDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [256:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [256:0] out_data,
  output logic         busy
);
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE. out_valid is high only in DONE. While
  // out_valid waits for out_ready, out_data stays bit-stable.

  localparam int RW = (NR_ROUNDS > 1) ? $clog2(NR_ROUNDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t          fsm_q;
  fsm_t          fsm_d;
  logic [256:0]  state;
  logic [RW-1:0] rnd;
  logic [256:0]  w_out;
  logic [256:0]  wo_out;
  logic [256:0]  round_out;
  logic          rnd_is_w;

  LolaP_round_w_inv u_round_w_inv (
    .din  (state),
    .dout (w_out)
  );

  LolaP_round_wo_inv u_round_wo_inv (
    .din  (state),
    .dout (wo_out)
  );

  // Round type for the current index. The w-type set matches the forward schedule.
  always_comb begin
    logic [31:0] k;
    k        = 32'(rnd);
    rnd_is_w = (k == 32'd1) || (k == 32'd3) || (k == 32'd4) ||
               (k == 32'd7) || (k == 32'd8);
    round_out = rnd_is_w ? w_out : wo_out;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic: capture in IDLE, count rounds in RUN, wait for the consumer in DONE.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: if (in_valid) fsm_d = S_RUN;
      S_RUN:  if (rnd == '0) fsm_d = S_DONE;
      S_DONE: if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Datapath: load the permuted state, then apply one inverse round per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
      rnd   <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            state <= in_data;
            rnd   <= RW'(NR_ROUNDS - 1);
          end
        end
        S_RUN: begin
          state <= round_out;
          if (rnd != '0) rnd <= rnd - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status outputs are decoded directly from the FSM state. The result comes straight from the state register.
  always_comb begin
    in_ready  = (fsm_q == S_IDLE);
    out_valid = (fsm_q == S_DONE);
    busy      = (fsm_q != S_IDLE);
    out_data  = state;
  end
endmodule

// File: tb/tb_lolap_inv_iter.sv
// Testbench for lolap_inv_iter, using NR_ROUNDS = 8, 1 and 9 instances.
// The stimulus is LolaP(X), computed by a forward model in this file. The
// expected output is X. A monitor pops the expected values and also models
// the IDLE/busy/DONE timing from the capture edge.
module tb_lolap_inv_iter;
  localparam logic [127:0] C_WO = 128'h243F6A8885A308D313198A2E03707344;
  localparam logic [127:0] C_W  = 128'hA4093822299F31D0082EFA98EC4E6C89;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic [256:0] in_data   [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [256:0] out_data  [3];
  int           nr_of     [3] = '{8, 1, 9};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [256:0] exp_q0[$];
  logic [256:0] exp_q1[$];
  logic [256:0] exp_q2[$];
  logic [256:0] pend_x   [3];
  logic         inflight [3];
  int           cap_e    [3];

  // Clock generation and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lolap_inv_iter #(.NR_ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .busy(busy[0]));

  lolap_inv_iter #(.NR_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .busy(busy[1]));

  lolap_inv_iter #(.NR_ROUNDS(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .busy(busy[2]));

  task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Forward LolaP reference model, written bit by bit.
  function automatic logic [256:0] rotl(input logic [256:0] v, input int s);
    logic [256:0] r;
    for (int b = 0; b < 257; b++) r[(b + s) % 257] = v[b];
    return r;
  endfunction

  function automatic logic [256:0] fwd_wo(input logic [256:0] x);
    logic [256:0] y;
    logic [127:0] c;
    c = C_WO;
    y = x;
    for (int j = 0; j < 128; j++) y[j] = x[j] ^ (x[128 + j] & x[129 + j]) ^ c[j];
    return rotl(y, 5);
  endfunction

  function automatic logic [256:0] fwd_w(input logic [256:0] x);
    logic [256:0] y;
    logic [127:0] c;
    c = C_W;
    y = x;
    for (int j = 0; j < 128; j++)
      y[128 + j] = x[128 + j] ^ x[j] ^ (x[(j + 127) % 128] & x[(j + 126) % 128]) ^ c[j];
    y[256] = x[256] ^ (x[0] & x[1]);
    return rotl(y, 11);
  endfunction

  function automatic logic [256:0] lolap(input logic [256:0] x, input int nr);
    logic [256:0] v;
    v = x;
    for (int k = 0; k < nr; k++) v = (k inside {1, 3, 4, 7, 8}) ? fwd_w(v) : fwd_wo(v);
    return v;
  endfunction

  function automatic logic [256:0] rand257();
    logic b;
    b = 1'($urandom_range(0, 1));
    return {b, $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard queue helpers, one queue per instance.
  function automatic void q_push(input int i, input logic [256:0] v);
    case (i)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [256:0] q_front(input int i);
    case (i)
      0: return exp_q0[0];
      1: return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  function automatic void q_pop(input int i);
    case (i)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endfunction

  // Monitor: models the IDLE/RUN/DONE timing from the capture edge, checks the status outputs, and pops results.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        inflight[i] = 1'b0;
        case (i)
          0: exp_q0.delete();
          1: exp_q1.delete();
          default: exp_q2.delete();
        endcase
      end else begin
        logic exp_ov;
        exp_ov = inflight[i] && ((cyc - cap_e[i]) >= nr_of[i]);
        check($sformatf("busy[%0d]", i), 257'(busy[i]), 257'(inflight[i]));
        check($sformatf("in_ready[%0d]", i), 257'(in_ready[i]), 257'(!inflight[i]));
        check($sformatf("out_valid[%0d]", i), 257'(out_valid[i]), 257'(exp_ov));
        if (exp_ov) begin
          if (q_size(i) == 0) begin
            check($sformatf("sb_nonempty[%0d]", i), 257'(0), 257'(1));
          end else begin
            check($sformatf("out_data[%0d]", i), out_data[i], q_front(i));
            if (out_ready[i]) q_pop(i);
          end
          if (out_ready[i]) inflight[i] = 1'b0;
        end else if (!inflight[i] && in_valid[i]) begin
          // in_ready is expected high here, so the coming edge is the capture edge E0.
          q_push(i, pend_x[i]);
          cap_e[i]    = cyc + 1;
          inflight[i] = 1'b1;
        end
      end
    end
  end

  // Driver: present LolaP(x) and hold in_valid until the capture edge.
  task automatic send(input int i, input logic [256:0] x);
    pend_x[i]   = x;
    in_data[i]  = lolap(x, nr_of[i]);
    in_valid[i] = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready[i]) break;
      if (t > 50) begin
        check($sformatf("capture_timeout[%0d]", i), 257'(0), 257'(1));
        break;
      end
    end
    @(posedge clk);
    #1 in_valid[i] = 1'b0;
  endtask

  // Driver: wait for the output handshake edge.
  task automatic wait_done(input int i);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (out_valid[i] && out_ready[i]) break;
      if (t > 50) begin
        check($sformatf("done_timeout[%0d]", i), 257'(0), 257'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [256:0] x;
    logic [256:0] y;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
      in_data[i]   = '0;
      pend_x[i]    = '0;
      inflight[i]  = 1'b0;
      cap_e[i]     = 0;
    end
    #1;
    check("rst_out_valid", 257'(out_valid[0]), 257'(0));
    check("rst_out_data", out_data[0], 257'(0));
    check("rst_busy", 257'(busy[0]), 257'(0));
    check("rst_in_ready", 257'(in_ready[0]), 257'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero vector and MSB-only vector.
    send(0, '0);
    wait_done(0);
    send(0, 257'(1) << 256);
    wait_done(0);

    // Random round trips with immediate out_ready.
    for (int n = 0; n < 1000; n++) begin
      send(0, rand257());
      wait_done(0);
    end

    // Input ignored while busy: toggle in_valid and in_data during RUN.
    x = rand257();
    send(0, x);
    repeat (8) begin
      in_valid[0] = 1'($urandom_range(0, 1));
      in_data[0]  = rand257();
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    wait_done(0);

    // Backpressure: hold out_ready low while a new state waits at the input.
    out_ready[0] = 1'b0;
    x = rand257();
    send(0, x);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid[0]) break;
    end
    @(posedge clk);
    #1;
    y            = rand257();
    pend_x[0]    = y;
    in_data[0]   = lolap(y, 8);
    in_valid[0]  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 257'(in_ready[0]), 257'(0));
      check("bp_hold", out_data[0], x);
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_after_hs", 257'(in_ready[0]), 257'(1));
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    wait_done(0);

    // Reset mid-run, while the round index is 4.
    send(0, rand257());
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 257'(out_valid[0]), 257'(0));
    check("mid_rst_busy", 257'(busy[0]), 257'(0));
    check("mid_rst_in_ready", 257'(in_ready[0]), 257'(1));
    check("mid_rst_out_data", out_data[0], 257'(0));
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, rand257());
    wait_done(0);

    // Parameter sweep: NR_ROUNDS = 1 and 9.
    for (int i = 1; i < 3; i++) begin
      send(i, '0);
      wait_done(i);
      send(i, 257'(1) << 256);
      wait_done(i);
      for (int n = 0; n < 200; n++) begin
        send(i, rand257());
        wait_done(i);
      end
    end

    repeat (5) @(posedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("sb_drained[%0d]", i), 257'(q_size(i)), 257'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lolap_inv_iter.md
# lolap_inv_iter

Iterative inverse of the 257-bit LolaP permutation. Accepts one 257-bit state over a valid/ready input handshake and applies the inverse rounds in reverse order, one round per clock. Returns the preimage over a valid/ready output handshake. Sits on the decryption/verification path opposite the unrolled forward LolaP core, trading latency for roughly 1/NR_ROUNDS of the round logic.

## Interface
- NR_ROUNDS, 8, number of rounds; must equal the forward permutation's round count (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_data holds a state to invert
- in_ready  out  1  block can accept a state (high only in IDLE)
- in_data  in  257  permuted state, bits [256:0]
- out_valid  out  1  out_data holds the inverted state
- out_ready  in  1  consumer accepts out_data
- out_data  out  257  inverted state, bits [256:0], driven directly from the state register
- busy  out  1  high in RUN or DONE

## Operation
- Round primitives: combinational 257-bit in/out inverse rounds LolaP_round_w_inv and LolaP_round_wo_inv, exact inverses of LolaP_round_w and LolaP_round_wo. One instance of each; a mux selects the result.
- Round type: index k is w-type when k ∈ {1,3,4,7,8}; all other indices are wo-type. This matches the forward schedule.
- Inverse order: k = NR_ROUNDS-1 down to 0. Forward round 0 is undone last.
- Registers:
  - state[256:0]
  - rnd, width max(1,$clog2(NR_ROUNDS))
  - FSM: IDLE, RUN, DONE
- IDLE:
  - in_ready=1.
  - On in_valid: state<=in_data, rnd<=NR_ROUNDS-1, go to RUN.
  - Otherwise hold.
- RUN:
  - Each cycle, state<=inv_round(rnd)(state).
  - If rnd==0, go to DONE; else rnd<=rnd-1.
  - in_valid is ignored (in_ready=0).
- DONE:
  - out_valid=1, out_data=state.
  - On out_ready: go to IDLE.
  - Otherwise hold; state and out_data stay bit-stable.
- No input/output overlap: a new state is accepted only in IDLE, at least one cycle after the DONE handshake.
- Reset (any time, including mid-RUN or DONE):
  - FSM→IDLE, state←0, rnd←0.
  - The in-flight block is discarded; no partial result is ever flagged valid.

## Timing
- Output reset values: out_valid=0, out_data=0, busy=0, in_ready=1 (in_ready is combinational from IDLE).
- Capture edge E0 is the rising edge with in_valid&&in_ready.
- Edges E1..E_NR_ROUNDS apply inverse rounds NR_ROUNDS-1..0.
- out_valid rises after edge E_NR_ROUNDS. With default NR_ROUNDS, that is 8 cycles after capture.
- The output handshake completes on the edge with out_valid&&out_ready, and the FSM returns to IDLE.
- Minimum block period: NR_ROUNDS+2 cycles (1 IDLE + NR_ROUNDS RUN + 1 DONE).
- busy=1 from the cycle after E0 until the output handshake edge.
- in_valid may be held high continuously; exactly one capture occurs per IDLE visit.
- The critical path is one inverse round plus a 257-bit 2:1 mux.

## Test plan
- Round trip, zero vector:
  - Stimulus: in_data=LolaP(257'h0) computed by the forward core in the bench.
  - Required: out_data=257'h0; out_valid asserts exactly 8 cycles after the capture edge.
- Round trip, MSB and random:
  - Stimulus: 257'h1_0000…0000 (bit 256 only) plus 1000 random 257-bit X, each as in_data=LolaP(X), out_ready=1.
  - Required: out_data==X for every block.
  - Required: in_ready is low for exactly NR_ROUNDS+1 cycles per block.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises; keep in_valid=1 with a new value.
  - Required: out_data stable, in_ready=0, no second capture.
  - Required: after out_ready=1, IDLE follows one cycle later, then the next value is captured.
- Reset mid-run:
  - Stimulus: assert rst asynchronously (mid-cycle) while rnd==4.
  - Required: out_valid=0, busy=0, in_ready=1 and out_data=0 immediately.
  - Required: the next block after rst deasserts inverts correctly with full 8-cycle latency.
- Input ignored while busy:
  - Stimulus: toggle in_valid/in_data every cycle during RUN.
  - Required: the result equals the inverse of the state captured at E0.
- Parameter sweep:
  - Stimulus: NR_ROUNDS=1 and NR_ROUNDS=9, each against a matching forward core.
  - Required: round-trip identity holds.
  - Required: latency is 1 and 9 cycles respectively.
  - Required: for NR_ROUNDS=9, index 8 uses the w-type inverse.
